conv_encoder_framed: RTL and testbench

// Rate-1/2, constraint-length-4 (8-state) convolutional encoder. It produces the 2-bit symbol stream consumed by the Viterbi decoder's d_in.

---
 rtl/viterbi_pkg.sv | 27 ++
 rtl/conv_enc_core.sv | 28 ++
 rtl/conv_encoder_framed.sv | 177 +++++++++++++++++
 tb/tb_conv_encoder_framed.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_pkg
//  Purpose  : Shared constants and types for the K=4 convolutional code used
//             by the framed encoder and the Viterbi decoder.
//  Contents : K, NUM_STATES, TAIL_LEN, default generators, enc_state_t
//  Revision : 1.0  initial release
// ============================================================================
package viterbi_pkg;

    localparam int K          = 4;
    localparam int NUM_STATES = 1 << (K - 1);
    localparam int TAIL_LEN   = K - 1;

    // Generator set matching the decoder branch-metric tables.
    // Bit K-1 taps the current input, bit 0 taps the oldest stored bit.
    localparam logic [K-1:0] G0_DEFAULT = 4'b1101;
    localparam logic [K-1:0] G1_DEFAULT = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_t;

endpackage : viterbi_pkg
`default_nettype wire

// File: rtl/conv_enc_core.sv
`default_nettype none
// ============================================================================
//  Module   : conv_enc_core
//  Purpose  : Combinational rate-1/2 symbol generator. Forms the code word
//             w = {b, sr} and returns the parity of each generator's taps.
//  Ports    : b    in  1    bit being encoded (data or tail zero)
//             sr   in  K-1  shift register, newest bit in the MSB
//             sym  out 2    {parity(G0 & w), parity(G1 & w)}
//  Revision : 1.0  initial release
// ============================================================================
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic         b,
    input  logic [K-2:0] sr,
    output logic [1:0]   sym
);

    logic [K-1:0] w_word;

    assign w_word = {b, sr};
    assign sym    = {^(G0 & w_word), ^(G1 & w_word)};

endmodule : conv_enc_core
`default_nettype wire

// File: rtl/conv_encoder_framed.sv
`default_nettype none
// ============================================================================
//  Module   : conv_encoder_framed
//  Purpose  : Framed rate-1/2, K=4 convolutional encoder. Emits one 2-bit
//             symbol per accepted data bit, then K-1 zero tail symbols so
//             every frame terminates in trellis state 0.
//  Ports    : clk, rst (async, active-low), enable (sync clear when low)
//             in_valid/in_ready/in_bit/in_last    : input bit handshake
//             sym_valid/sym_ready/sym/sym_last    : output symbol handshake
//             busy      : frame in progress or symbol pending
//             len_trunc : 1-cycle pulse, frame cut at MAX_LEN bits
//  Revision : 1.0  initial release
// ============================================================================
module conv_encoder_framed
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0      = G0_DEFAULT,
    parameter logic [K-1:0] G1      = G1_DEFAULT,
    parameter int           MAX_LEN = 1021
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [1:0] sym,
    output logic       sym_last,
    output logic       busy,
    output logic       len_trunc
);

    localparam logic [9:0] c_LEN_LIMIT = 10'(MAX_LEN - 1);
    localparam logic [1:0] c_TAIL_LAST = 2'(TAIL_LEN - 1);

    enc_state_t   r_state;
    enc_state_t   w_state_nxt;
    logic [K-2:0] r_sr;
    logic [9:0]   r_bit_cnt;
    logic [1:0]   r_tail_cnt;
    logic         r_sym_valid;
    logic [1:0]   r_sym;
    logic         r_sym_last;
    logic         r_len_trunc;

    logic         w_load_ok;
    logic         w_in_ready;
    logic         w_load;
    logic         w_b;
    logic         w_set_last;
    logic         w_trunc;
    logic [1:0]   w_sym;

    // The output register can take a new symbol when empty or draining now.
    assign w_load_ok = !r_sym_valid || sym_ready;

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .b   (w_b),
        .sr  (r_sr),
        .sym (w_sym)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (!enable) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        w_b         = 1'b0;
        w_set_last  = 1'b0;
        w_trunc     = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = enable && w_load_ok;
                if (w_in_ready && in_valid) begin
                    w_load      = 1'b1;
                    w_b         = in_bit;
                    w_state_nxt = in_last ? TAIL : DATA;
                end
            end
            DATA: begin
                w_in_ready = enable && w_load_ok;
                if (w_in_ready && in_valid) begin
                    w_load = 1'b1;
                    w_b    = in_bit;
                    if (in_last) begin
                        w_state_nxt = TAIL;
                    end else if (r_bit_cnt == c_LEN_LIMIT) begin
                        // This bit is the MAX_LEN-th: close the frame here.
                        w_state_nxt = TAIL;
                        w_trunc     = 1'b1;
                    end
                end
            end
            TAIL: begin
                if (enable && w_load_ok) begin
                    w_load = 1'b1;
                    if (r_tail_cnt == c_TAIL_LAST) begin
                        w_set_last  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_tail_cnt  <= '0;
            r_sym_valid <= 1'b0;
            r_sym       <= '0;
            r_sym_last  <= 1'b0;
            r_len_trunc <= 1'b0;
        end else if (!enable) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_tail_cnt  <= '0;
            r_sym_valid <= 1'b0;
            r_sym       <= '0;
            r_sym_last  <= 1'b0;
            r_len_trunc <= 1'b0;
        end else begin
            r_len_trunc <= w_trunc;

            if (w_load) begin
                r_sr        <= {w_b, r_sr[K-2:1]};
                r_sym       <= w_sym;
                r_sym_last  <= w_set_last;
                r_sym_valid <= 1'b1;
            end else if (sym_ready) begin
                r_sym_valid <= 1'b0;
                r_sym_last  <= 1'b0;
            end

            if (w_load) begin
                case (r_state)
                    IDLE:    r_bit_cnt <= 10'd1;
                    DATA:    r_bit_cnt <= r_bit_cnt + 10'd1;
                    TAIL:    if (w_set_last) r_bit_cnt <= '0;
                    default: r_bit_cnt <= '0;
                endcase
            end

            if (w_load && (r_state == TAIL)) begin
                r_tail_cnt <= w_set_last ? 2'd0 : (r_tail_cnt + 2'd1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign sym_valid = r_sym_valid;
    assign sym       = r_sym;
    assign sym_last  = r_sym_last;
    assign len_trunc = r_len_trunc;
    assign busy      = (r_state != IDLE) || r_sym_valid;

endmodule : conv_encoder_framed
`default_nettype wire

// File: tb/tb_conv_encoder_framed.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_encoder_framed
//  Purpose  : Self-checking bench for conv_encoder_framed. Expected symbol
//             streams come from a textbook generator-polynomial model of the
//             code applied to each frame (data bits followed by K-1 zeros).
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_encoder_framed;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       enable    = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_bit    = 1'b0;
    logic       in_last   = 1'b0;
    logic       sym_ready = 1'b0;
    logic       in_ready;
    logic       sym_valid;
    logic [1:0] sym;
    logic       sym_last;
    logic       busy;
    logic       len_trunc;

    always #5 clk = ~clk;

    conv_encoder_framed dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym       (sym),
        .sym_last  (sym_last),
        .busy      (busy),
        .len_trunc (len_trunc)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    bit [3:0]   g0 = 4'b1101;
    bit [3:0]   g1 = 4'b1111;
    logic [1:0] t1_tab [7] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};

    logic [1:0] got_sym[$];
    bit         got_last[$];
    int         got_cyc[$];
    logic [1:0] exp_sym[$];
    bit         exp_last[$];

    int         acc_cnt   = 0;
    int         trunc_cnt = 0;
    int         trunc_at  = -1;
    int         ready_mode = 0;
    bit         held      = 1'b0;
    logic [1:0] held_sym;
    logic       held_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: handshakes captured on the falling edge, which reflects
    // what the DUT will see at the next rising edge.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("stall_valid", sym_valid, 1'b1);
                chk("stall_sym", sym, held_sym);
                chk("stall_last", sym_last, held_last);
            end
            if (len_trunc) begin
                trunc_cnt++;
                trunc_at = acc_cnt;
            end
            if (enable && sym_valid && sym_ready) begin
                got_sym.push_back(sym);
                got_last.push_back(sym_last);
                got_cyc.push_back(cyc);
            end
            if (enable && in_valid && in_ready) acc_cnt++;
            held      = enable && sym_valid && !sym_ready;
            held_sym  = sym;
            held_last = sym_last;
        end
    end

    // Reference: y_k[n] = XOR_j g_k[3-j] * x[n-j], x = frame bits then 3 zeros.
    function automatic void model_frame(input bit bits[$]);
        bit x[$];
        x = bits;
        for (int i = 0; i < 3; i++) x.push_back(1'b0);
        for (int n = 0; n < x.size(); n++) begin
            bit s1 = 1'b0;
            bit s0 = 1'b0;
            for (int j = 0; j < 4; j++) begin
                bit xb = (n - j >= 0) ? x[n - j] : 1'b0;
                s1 ^= g0[3 - j] & xb;
                s0 ^= g1[3 - j] & xb;
            end
            exp_sym.push_back({s1, s0});
            exp_last.push_back(n == x.size() - 1);
        end
    endfunction

    task automatic clear_all();
        got_sym.delete(); got_last.delete(); got_cyc.delete();
        exp_sym.delete(); exp_last.delete();
        acc_cnt = 0; trunc_cnt = 0; trunc_at = -1;
    endtask

    task automatic send_bits(input bit bits[$], input bit term, input int gap_max);
        for (int i = 0; i < bits.size(); i++) begin
            int t;
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_bit   = bits[i];
            in_last  = term && (i == bits.size() - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                t++;
                if (t > 2000) begin
                    chk("accept_timeout", in_ready, 1'b1);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input int n);
        int t = 0;
        while (got_sym.size() < n && t < 5000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_count"}, got_sym.size(), exp_sym.size());
        for (int i = 0; i < got_sym.size() && i < exp_sym.size(); i++) begin
            chk({tag, "_sym"}, got_sym[i], exp_sym[i]);
            chk({tag, "_last"}, got_last[i], exp_last[i]);
        end
    endtask

    task automatic compare_t1(input string tag, input int n);
        chk({tag, "_count"}, got_sym.size(), n);
        for (int i = 0; i < n && i < got_sym.size(); i++) begin
            chk({tag, "_sym"}, got_sym[i], t1_tab[i]);
            chk({tag, "_last"}, got_last[i], i == 6);
        end
    endtask

    initial begin
        bit f1[$];
        bit one[$];
        bit fr[$];
        bit big[$];
        bit part[$];
        int t;

        f1  = '{1'b1, 1'b0, 1'b1, 1'b1};
        one = '{1'b1};

        fork
            forever begin
                @(posedge clk); #1;
                case (ready_mode)
                    0:       sym_ready = 1'b1;
                    1:       sym_ready = ~sym_ready;
                    default: sym_ready = 1'($urandom_range(0, 1));
                endcase
            end
        join_none

        // Reset state
        enable = 1'b1;
        @(negedge clk);
        chk("rst_sym_valid", sym_valid, 1'b0);
        chk("rst_sym", sym, 2'b00);
        chk("rst_sym_last", sym_last, 1'b0);
        chk("rst_len_trunc", len_trunc, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Reference frame with free-flowing output
        ready_mode = 0;
        clear_all();
        send_bits(f1, 1'b1, 0);
        drain(7);
        compare_t1("t1", 7);

        // Same frame with back-pressure toggling every cycle
        ready_mode = 1;
        clear_all();
        model_frame(f1);
        send_bits(f1, 1'b1, 0);
        drain(exp_sym.size());
        compare_stream("t2");

        // Two 1-bit frames back to back, no bubble between
        ready_mode = 0;
        @(posedge clk); #1;
        clear_all();
        model_frame(one);
        model_frame(one);
        send_bits(one, 1'b1, 0);
        send_bits(one, 1'b1, 0);
        drain(exp_sym.size());
        compare_stream("t3");
        for (int i = 1; i < got_cyc.size(); i++)
            chk("t3_gap", got_cyc[i] - got_cyc[i - 1], 1);

        // Random frames, random gaps, random back-pressure
        ready_mode = 2;
        clear_all();
        for (int f = 0; f < 6; f++) begin
            int len = $urandom_range(1, 24);
            fr.delete();
            for (int i = 0; i < len; i++) fr.push_back(1'($urandom_range(0, 1)));
            model_frame(fr);
            send_bits(fr, 1'b1, 2);
        end
        drain(exp_sym.size());
        compare_stream("t4");
        chk("t4_no_trunc", trunc_cnt, 0);

        // Length truncation: 1030 bits without in_last, then one with it
        ready_mode = 0;
        @(posedge clk); #1;
        clear_all();
        big.delete();
        for (int i = 0; i < 1031; i++) big.push_back(1'($urandom_range(0, 1)));
        part = big[0:1020];
        model_frame(part);
        part = big[1021:1030];
        model_frame(part);
        send_bits(big, 1'b1, 0);
        drain(exp_sym.size());
        compare_stream("t5");
        chk("t5_trunc_cnt", trunc_cnt, 1);
        chk("t5_trunc_at", trunc_at, 1021);

        // enable=0 during the tail after the fifth symbol
        clear_all();
        send_bits(f1, 1'b1, 0);
        t = 0;
        while (got_sym.size() < 5 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_sym_valid", sym_valid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_in_ready", in_ready, 1'b0);
        chk("t6_sym", sym, 2'b00);
        compare_t1("t6_pre", 5);
        @(posedge clk); #1;
        enable = 1'b1;
        clear_all();
        send_bits(f1, 1'b1, 0);
        drain(7);
        compare_t1("t6_post", 7);

        // Asynchronous reset mid-DATA while a symbol is pending
        clear_all();
        in_valid = 1'b1;
        in_bit   = 1'b1;
        in_last  = 1'b0;
        t = 0;
        while (acc_cnt < 2 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("t7_pre_valid", sym_valid, 1'b1);
        @(negedge clk); #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t7_sym_valid", sym_valid, 1'b0);
        chk("t7_sym", sym, 2'b00);
        chk("t7_sym_last", sym_last, 1'b0);
        chk("t7_len_trunc", len_trunc, 1'b0);
        chk("t7_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_all();
        send_bits(f1, 1'b1, 0);
        drain(7);
        compare_t1("t7_post", 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_conv_encoder_framed
`default_nettype wire
